// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode/CU.
// Holds the PC, issues single-outstanding word requests to instruction
// memory, buffers returned words with their PC in a small FIFO and
// presents the head through a valid/ready handshake. Supports redirect
// with flush and a sticky halt.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/gnt          request channel (transfer on req && gnt)
//   imem_rvalid/rdata          in-order response, one per accepted request
//   inst_valid/inst/inst_pc    buffer head towards decode
//   inst_ready                 downstream pop strobe
//   redirect_valid/pc          branch/jump redirect, flushes the buffer
//   halt_req / halted          enter sticky halt / halt status
//
// Optional build macro FETCH_PERF_EN adds saturating counters
// perf_fetched (buffered words) and perf_stall (empty, non-halted cycles).

module fetch_unit #(
    parameter int unsigned        ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(32'h0000_0000),
    parameter int unsigned        IBUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int unsigned PTR_W = (IBUF_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                out_q, out_d;
    logic                drop_q, drop_d;

    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         buf_inst_q [IBUF_DEPTH];
    logic [ADDR_W-1:0]   buf_pc_q   [IBUF_DEPTH];

    logic [CNT_W-1:0]    occ;
    logic                can_issue;
    logic                grant;
    logic                full;
    logic                push;
    logic                pop;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // Outstanding request reserves a buffer slot so a response is never
    // returned into a full buffer.
    assign occ       = cnt_q + CNT_W'(out_q);
    assign can_issue = (state_q == S_FETCH) && (occ < CNT_W'(IBUF_DEPTH));
    assign grant     = imem_req && imem_gnt;
    assign full      = (cnt_q == CNT_W'(IBUF_DEPTH));

    assign inst_valid = (cnt_q != '0);

    // Redirect cancels any same-cycle buffer traffic.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = imem_rvalid && !drop_q && !redirect_valid &&
                  (!full || pop);

    assign inst    = inst_valid ? buf_inst_q[rd_ptr_q] : '0;
    assign inst_pc = inst_valid ? buf_pc_q[rd_ptr_q]   : '0;

    assign imem_addr = pc_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = out_d ? S_WAIT : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (grant) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (imem_rvalid) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Request is held low while reset is asserted even though the state
    // register already sits in FETCH.
    always_comb begin
        imem_req = rst_n && can_issue;
        halted   = (state_q == S_HALT);
    end

    // ------------------------------------------------------------------
    // PC / request tracking next state
    // ------------------------------------------------------------------
    always_comb begin
        out_d = out_q;
        if (imem_rvalid) begin
            out_d = 1'b0;
        end
        if (grant) begin
            out_d = 1'b1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (redirect_valid) begin
            // Whatever is still in flight after this edge belongs to the
            // old path, including a request granted this very cycle.
            drop_d = out_d;
        end else if (imem_rvalid) begin
            drop_d = 1'b0;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (grant) begin
            req_addr_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (grant) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            out_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer (circular FIFO)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(IBUF_DEPTH); i++) begin
                buf_inst_q[i] <= '0;
                buf_pc_q[i]   <= '0;
            end
        end else if (push) begin
            buf_inst_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating, survive redirect)
    // ------------------------------------------------------------------
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (!inst_valid && !halted &&
                (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit.
// A queue-based reference model and a variable-latency memory live here.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0000_0000),
        .IBUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
`ifdef FETCH_PERF_EN
       ,.perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_oaddr;
    bit          m_out;
    bit          m_drop;
    bit          m_halt;
    logic [31:0] m_fetched;
    logic [31:0] m_stall;

    // memory model
    bit          mb;
    int unsigned ml;
    logic [31:0] ma;

    // knobs
    int unsigned gnt_pct = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    int unsigned rdy_pct = 100;

    bit at_sample   = 1'b0;
    bit rel_pending = 1'b0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound(input string tag, input int k, input int lim);
        n_tests++;
        assert (k < lim) else begin
            n_fail++;
            $error("FAIL %s observed=%0d cycles expected<%0d", tag, k, lim);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = 32'h0;
        m_oaddr   = 32'h0;
        m_out     = 1'b0;
        m_drop    = 1'b0;
        m_halt    = 1'b0;
        m_fetched = 32'h0;
        m_stall   = 32'h0;
        mb        = 1'b0;
        ml        = 0;
        ma        = 32'h0;
    endtask

    task automatic to_sample();
        @(negedge clk);
        if (rel_pending) begin
            rst_n       = 1'b1;
            rel_pending = 1'b0;
        end
        #1;
    endtask

    task automatic sync();
        if (!at_sample) begin
            to_sample();
            at_sample = 1'b1;
        end
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model.
    task automatic tick(input bit r, input logic [31:0] rpc, input bit h);
        bit   ereq, v, g, rd, gr, pop, push;
        if (!at_sample) begin
            to_sample();
        end
        at_sample = 1'b0;

        ereq = rst_n && !m_halt && !m_out && (mq.size() < DEPTH);
        chk("imem_req", imem_req, ereq);
        if (ereq) begin
            chk("imem_addr", imem_addr, m_pc);
        end
        chk("inst_valid", inst_valid, mq.size() != 0);
        chk("inst", inst, (mq.size() != 0) ? mq[0].w : 32'h0);
        chk("inst_pc", inst_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
        chk("halted", halted, m_halt);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
`endif

        v  = mb && (ml == 1);
        g  = !mb && imem_req && ($urandom_range(99, 0) < gnt_pct);
        rd = $urandom_range(99, 0) < rdy_pct;

        imem_gnt       = g;
        imem_rvalid    = v;
        imem_rdata     = v ? memword(ma) : $urandom;
        inst_ready     = rd;
        redirect_valid = r;
        redirect_pc    = rpc;
        halt_req       = h;

        if (rst_n) begin
            gr   = ereq && g;
            pop  = (mq.size() != 0) && rd;
            push = v && m_out && !m_drop;
            if (mq.size() == 0 && !m_halt) begin
                m_stall++;
            end
            if (r) begin
                mq.delete();
                m_drop = gr || (m_out && !v);
                m_out  = m_drop;
                if (gr) begin
                    m_oaddr = m_pc;
                end
                m_pc   = rpc & ~32'h3;
                m_halt = 1'b0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                end
                if (push) begin
                    mq.push_back('{w: memword(ma), pc: m_oaddr});
                    m_fetched++;
                end
                if (v) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end
                if (gr) begin
                    m_out   = 1'b1;
                    m_oaddr = m_pc;
                    m_pc    = m_pc + 32'd4;
                end
                if (h) begin
                    m_halt = 1'b1;
                end
            end
        end

        if (v) begin
            mb = 1'b0;
        end else if (mb) begin
            ml--;
        end
        if (g) begin
            mb = 1'b1;
            ml = $urandom_range(lat_max, lat_min);
            ma = imem_addr;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        model_reset();
        #1;
        at_sample = 1'b1;
        repeat (n) tick(1'b0, 32'h0, 1'b0);
        rel_pending = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) tick(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        int k;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        model_reset();

        // reset values, then streaming with 1-cycle memory
        do_reset(3);
        run(12);

        // backpressure: only 0x0 and 0x4 may be fetched
        rdy_pct = 0;
        do_reset(2);
        run(10);
        sync();
        chk("bp_req_low", imem_req, 1'b0);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_next_addr", imem_addr, 32'h8);
        rdy_pct = 100;
        run(8);

        // redirect while a 3-cycle response is outstanding
        lat_min = 3;
        lat_max = 3;
        k = 0;
        while (!m_out && k < 20) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("redir_wait_out", k, 20);
        tick(1'b1, 32'h0000_0103, 1'b0);
        sync();
        chk("redir_empty", inst_valid, 1'b0);
        chk("redir_addr", imem_addr, 32'h100);
        k = 0;
        while (mq.size() == 0 && k < 30) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("redir_wait_inst", k, 30);
        sync();
        chk("redir_first_pc", inst_pc, 32'h100);
        run(6);

        // halt with one request outstanding
        k = 0;
        while (!m_out && k < 20) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("halt_wait_out", k, 20);
        tick(1'b0, 32'h0, 1'b1);
        run(20);
        sync();
        chk("halt_sticky", halted, 1'b1);
        chk("halt_no_req", imem_req, 1'b0);
        tick(1'b1, 32'h0000_0040, 1'b0);
        sync();
        chk("halt_exit", halted, 1'b0);
        chk("halt_exit_req", imem_req, 1'b1);
        chk("halt_exit_addr", imem_addr, 32'h40);
        run(6);

        // PC wrap
        lat_min = 1;
        lat_max = 2;
        tick(1'b1, 32'hFFFF_FFFE, 1'b0);
        k = 0;
        while (m_pc != 32'h0 && k < 30) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("wrap_wait", k, 30);
        k = 0;
        while (!(mq.size() < DEPTH && !m_out) && k < 30) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("wrap_wait_idle", k, 30);
        sync();
        chk("wrap_addr", imem_addr, 32'h0);
        run(6);

        // five buffered words, then a dropped sixth response
        lat_min = 1;
        lat_max = 1;
        do_reset(2);
        k = 0;
        while (!(m_fetched == 32'd5 && m_out) && k < 40) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        bound("perf_wait", k, 40);
        gnt_pct = 0;
        tick(1'b1, 32'h0000_0200, 1'b0);
        run(5);
        sync();
        chk("five_fetched", m_fetched, 32'd5);
`ifdef FETCH_PERF_EN
        chk("perf_fetched5", perf_fetched, 32'd5);
        chk("perf_stall_cnt", perf_stall, m_stall);
`endif
        gnt_pct = 100;
        run(4);

        // randomized traffic with a mid-transaction reset
        gnt_pct = 60;
        rdy_pct = 60;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            bit          r;
            bit          h;
            logic [31:0] a;
            r = ($urandom_range(99, 0) < 3);
            h = ($urandom_range(99, 0) < 2);
            a = $urandom;
            if (i == 1500) begin
                do_reset(2);
            end else begin
                tick(r, a, h);
            end
        end
        run(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit `CU`.
- Holds the PC and issues word requests to instruction memory over a valid/ready request channel. Memory responses are variable-latency.
- Buffers fetched words with their PC and presents them to decode/CU through a valid/ready handshake.
- Supports branch/jump redirect with flush, and a sticky halt driven by the SYSTEM opcode path.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IBUF_DEPTH, 2, instruction buffer entries; legal values are 2 or 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  word-aligned fetch address.
- imem_gnt  in  1  memory accepts request; transfer when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid, one cycle per accepted request, in order.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  buffer head valid.
- inst  out  32  head instruction; inst[6:0] feeds CU opcode decode.
- inst_pc  out  ADDR_W  PC of the head instruction.
- inst_ready  in  1  downstream consumes head; pop when inst_valid && inst_ready.
- redirect_valid  in  1  branch/JAL/JALR taken this cycle.
- redirect_pc  in  ADDR_W  target address; bits[1:0] are ignored and forced to 0.
- halt_req  in  1  pulse from the SYSTEM decode path (CU PC_load low).
- halted  out  1  fetch stopped.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, buffer empty, outstanding=0, drop=0.
  - imem_req=0, inst_valid=0, inst=0, inst_pc=0, halted=0.
- States:
  - FETCH: issue requests.
  - WAIT: one request outstanding.
  - HALT: no requests.
- At most one outstanding request. Transaction latency is ≥1 cycle from grant to rvalid.
- Issue condition, in FETCH: imem_req=1 when (buffer count + outstanding) < IBUF_DEPTH.
  - imem_addr=pc.
  - On grant: pc<=pc+4 (wraps mod 2^ADDR_W), go to WAIT.
  - imem_req holds with a stable address until granted.
- WAIT:
  - On imem_rvalid, push {imem_rdata, addr_of_request} unless drop=1.
  - Return to FETCH the same cycle.
  - A new request may assert in the cycle after rvalid, not the same cycle.
- Buffer:
  - FIFO, head presented combinationally from storage; fetch-to-inst_valid latency is 1 cycle after rvalid.
  - Push and pop in the same cycle are allowed at any occupancy, including full.
  - Pop when empty is ignored.
  - Push never occurs when full; the issue rule guarantees this.
- Redirect (redirect_valid=1), highest priority over everything except reset:
  - Buffer flushed and inst_valid=0 next cycle.
  - pc<=redirect_pc & ~3.
  - If a request is outstanding, drop<=1; its response is discarded and drop clears on that rvalid.
  - Any same-cycle push/pop is cancelled.
  - Also exits HALT (halted<=0) and returns to FETCH or WAIT as appropriate.
  - A redirect in the same cycle as a grant: the granted request is marked dropped.
- Halt (halt_req=1, no redirect):
  - Enter HALT at the next edge; halted=1.
  - An outstanding response still completes and is buffered.
  - The buffer still drains to downstream.
  - The pc value is frozen.
  - If redirect_valid and halt_req are both high in the same cycle, redirect wins and halt is ignored.
- Reset mid-transaction: all state is cleared immediately. Any later rvalid for a pre-reset request is not expected; a pre-reset rvalid arriving after reset is pushed (memory is reset together).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32-bit) and perf_stall (32-bit).
  - perf_fetched counts non-dropped pushes.
  - perf_stall counts cycles with inst_valid=0 && !halted.
  - Both counters reset to 0 on rst_n, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release; memory grants immediately with 1-cycle latency; inst_ready=1 → imem_addr sequence 0x0,0x4,0x8; inst_pc follows with 0x0 first; inst equals memory contents; no gaps beyond 1 bubble per fetch.
- inst_ready=0 with IBUF_DEPTH=2 → exactly 2 requests issued (0x0,0x4), then imem_req=0. Raise inst_ready → pops 0x0 and fetch 0x8 resumes.
- Redirect to 0x103 while the 0x8 response is outstanding with 3-cycle latency → that response is discarded, next imem_addr=0x100, first inst_pc=0x100, buffer empty in the cycle after redirect.
- halt_req pulse with one request outstanding → response buffered, halted=1, no further imem_req for 20 cycles. redirect to 0x40 → halted=0, imem_addr=0x40.
- pc=0xFFFF_FFFC fetch → next imem_addr=0x0000_0000 (wrap).
- With FETCH_PERF_EN defined: 5 fetches then 1 redirect-dropped response → perf_fetched=5; perf_stall equals the counted empty non-halted cycles.
